fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/cpu_pkg.sv | 15 +
 rtl/PCadder.sv | 11 +
 rtl/fetch_stage.sv | 92 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths, reset vector and the fetch-stage state encoding.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned INSTR_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StStall,
        StRedirect
    } fetch_state_t;

endpackage

// File: rtl/PCadder.sv
// Sequential next-PC incrementer; wraps naturally at the top of the address space.
module PCadder #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] address,
    output logic [ADDR_W-1:0] PC
);

    assign PC = address + ADDR_W'(1);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a synchronous imem, handles decode back-pressure and
// taken-branch redirects with a single bubble.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned         ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned         INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0]   RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_en,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic              if_valid_q, if_valid_d;
    logic [ADDR_W-1:0] pc_plus;
    logic              fetch_en;

    PCadder #(
        .ADDR_W (ADDR_W)
    ) u_pc_adder (
        .address (pc_q),
        .PC      (pc_plus)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        fetch_en   = 1'b0;
        case (state_q)
            StBoot: begin
                fetch_en   = 1'b1;
                pc_d       = pc_plus;
                if_pc_d    = pc_q;
                if_valid_d = 1'b1;
                state_d    = StRun;
            end
            default: begin
                // Run, Stall and Redirect share one rule set; a branch beats a stall.
                if (branch_taken) begin
                    fetch_en   = 1'b1;
                    pc_d       = branch_target;
                    if_valid_d = 1'b0;
                    state_d    = StRedirect;
                end else if (stall) begin
                    state_d = StStall;
                end else begin
                    fetch_en   = 1'b1;
                    pc_d       = pc_plus;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    state_d    = StRun;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
        end
    end

    // Memory keeps its last word while disabled, so if_instr stays aligned with if_pc.
    assign imem_en   = fetch_en & rst_n;
    assign imem_addr = pc_q;
    assign if_pc     = if_pc_q;
    assign if_valid  = if_valid_q;
    assign if_instr  = imem_rdata;

endmodule
